// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO; frames go out back-to-back while data is queued.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between data bit 7 and stop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          iclk,
    input  logic                          transmit_reset_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          uart_transmit
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic                tx_reg, tx_next;
    logic [7:0]          tx_byte_reg, tx_byte_next;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]      count_reg, count_next;
    logic                full_reg;
    logic                overflow_reg;

    logic                wr_accept;
    logic                pop;
    logic                baud_done;

    assign wr_accept = wr_en && !full_reg;
    assign baud_done = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge iclk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + (PTR_W+1)'(1);
            2'b01:   count_next = count_reg - (PTR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Frame sequencer: the FIFO head is popped on the same edge the start bit begins.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_next     = bit_reg;
        tx_next      = tx_reg;
        tx_byte_next = tx_byte_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (count_reg != '0) begin
                    pop          = 1'b1;
                    tx_byte_next = mem[rd_ptr_reg];
                    tx_next      = 1'b0;
                    baud_next    = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = tx_byte_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = ^tx_byte_reg;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        tx_next  = tx_byte_reg[bit_reg + 3'd1];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (count_reg != '0) begin
                        pop          = 1'b1;
                        tx_byte_next = mem[rd_ptr_reg];
                        tx_next      = 1'b0;
                        state_next   = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!transmit_reset_n) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            tx_reg       <= 1'b1;
            tx_byte_reg  <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            tx_reg       <= tx_next;
            tx_byte_reg  <= tx_byte_next;
            count_reg    <= count_next;
            full_reg     <= (count_next == (PTR_W+1)'(FIFO_DEPTH));
            overflow_reg <= overflow_reg | (wr_en & full_reg);
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    assign fifo_full     = full_reg;
    assign fifo_count    = count_reg;
    assign busy          = (state_reg != IDLE);
    assign overflow      = overflow_reg;
    assign uart_transmit = tx_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level reference model predicts every output each cycle.
module tb_uart_tx_fifo;
    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       iclk;
    logic       transmit_reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       uart_transmit;

    int checks = 0;
    int errors = 0;

    // Reference model state: queued bytes plus position inside the current frame.
    logic [7:0]  mq[$];
    bit          m_active;
    int          m_idx;
    logic [10:0] m_frame;
    bit          m_ovf;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .iclk             (iclk),
        .transmit_reset_n (transmit_reset_n),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .fifo_full        (fifo_full),
        .fifo_count       (fifo_count),
        .busy             (busy),
        .overflow         (overflow),
        .uart_transmit    (uart_transmit)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        m_frame = '1;
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[1+i] = d[i];
        if (FL == 11) m_frame[9] = ^d;
        m_frame[FL-1] = 1'b1;
        m_active = 1'b1;
        m_idx = 0;
        $display("frame start data=0x%02h", d);
    endtask

    task automatic model_step();
        int  pre_count;
        bit  do_pop;
        if (!transmit_reset_n) begin
            mq.delete();
            m_active = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
            return;
        end
        pre_count = mq.size();
        do_pop = 1'b0;
        if (m_active) begin
            m_idx++;
            if (m_idx == FL * CPB) begin
                m_active = 1'b0;
                do_pop = (pre_count != 0);
            end
        end else begin
            do_pop = (pre_count != 0);
        end
        if (do_pop) start_frame(mq.pop_front());
        if (wr_en) begin
            if (pre_count < DEPTH) begin
                mq.push_back(wr_data);
                $display("write 0x%02h accepted", wr_data);
            end else begin
                m_ovf = 1'b1;
                $display("write 0x%02h dropped", wr_data);
            end
        end
    endtask

    task automatic tick();
        logic exp_line;
        @(posedge iclk);
        model_step();
        @(negedge iclk);
        exp_line = m_active ? m_frame[m_idx / CPB] : 1'b1;
        check("line",     32'(uart_transmit), 32'(exp_line));
        check("busy",     32'(busy),          32'(m_active));
        check("count",    32'(fifo_count),    32'(mq.size()));
        check("full",     32'(fifo_full),     32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow),      32'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [6];
        burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h00;
        burst[3] = 8'hFF; burst[4] = 8'h11; burst[5] = 8'h33;
        transmit_reset_n = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        m_active = 1'b0;
        m_idx = 0;
        m_ovf = 1'b0;
        m_frame = '1;

        run(5);
        transmit_reset_n = 1'b1;
        run(3);

        // Single byte from idle.
        write_byte(8'h0D);
        run(FL * CPB + 10);

        // Back-to-back burst filling the FIFO, last write lands while full.
        for (int i = 0; i < 6; i++) write_byte(burst[i]);
        run(5 * FL * CPB + 20);

        // Reset during data bit 3 of 0xA5, then a clean frame.
        write_byte(8'hA5);
        run(1 + CPB + 3 * CPB + 5);
        transmit_reset_n = 1'b0;
        tick();
        transmit_reset_n = 1'b1;
        run(3);
        write_byte(8'h0D);
        run(FL * CPB + 10);

        // Parity-relevant byte (odd weight).
        write_byte(8'h07);
        run(FL * CPB + 10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 99) < 12);
            wr_data = 8'($urandom);
            transmit_reset_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        wr_en = 1'b0;
        transmit_reset_n = 1'b1;
        run(5 * FL * CPB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
